// File: rtl/cache_pkg.sv
// Shared types and width helpers for the cache replacement logic.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cache_pkg;

  // Fill sequencing states of the victim selector
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOOKUP   = 2'd1,
    WAIT_ACK = 2'd2
  } plru_state_e;

  // Width of a way index; never narrower than one bit
  function automatic int way_bits(input int num_ways);
    return (num_ways < 2) ? 1 : $clog2(num_ways);
  endfunction

  // Width of a set index; a single set still gets a one-bit index
  function automatic int set_bits(input int num_sets);
    return (num_sets < 2) ? 1 : $clog2(num_sets);
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree-PLRU helper: victim walk of a tree plus the tree after touching a way.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module plru_tree
  import cache_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int WAY_BITS = way_bits(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] tree_in,
  input  logic [WAY_BITS-1:0] touch_way,
  output logic [WAY_BITS-1:0] victim_way,
  output logic [NUM_WAYS-2:0] tree_out
);

  // Heap layout: level l holds nodes (2^l - 1) .. (2^(l+1) - 2); the node on a
  // way's path at level l is picked by that way's top l index bits.

  // Walk from the root: each node bit is the next way-index bit, MSB first
  always_comb begin
    logic [WAY_BITS-1:0] walk;
    walk = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      for (int k = 0; k < (1 << l); k++) begin
        if ((walk >> (WAY_BITS - l)) == WAY_BITS'(k)) begin
          walk[WAY_BITS-1-l] = tree_in[(1 << l) - 1 + k];
        end
      end
    end
    victim_way = walk;
  end

  // Point every node on touch_way's path at the opposite subtree
  always_comb begin
    tree_out = tree_in;
    for (int l = 0; l < WAY_BITS; l++) begin
      for (int k = 0; k < (1 << l); k++) begin
        if ((touch_way >> (WAY_BITS - l)) == WAY_BITS'(k)) begin
          tree_out[(1 << l) - 1 + k] = ~touch_way[WAY_BITS-1-l];
        end
      end
    end
  end

endmodule

// File: rtl/plru_victim_sel.sv
// Per-set tree-PLRU victim selector; lowest invalid way wins over the tree victim.
// Latency: victim_valid rises 2 cycles after an accepted fill_req, held until fill_ack.
// Backpressure: fill_req is dropped while fill_busy=1; no queueing.
module plru_victim_sel
  import cache_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 4,
  parameter int WAY_BITS = way_bits(NUM_WAYS),
  parameter int SET_BITS = set_bits(NUM_SETS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                hit_valid,
  input  logic [SET_BITS-1:0] hit_set,
  input  logic [WAY_BITS-1:0] hit_way,
  input  logic                fill_req,
  input  logic [SET_BITS-1:0] fill_set,
  output logic                fill_busy,
  output logic                victim_valid,
  output logic [WAY_BITS-1:0] victim_way,
  input  logic                fill_ack
);

  plru_state_e         state_q, state_d;
  logic [SET_BITS-1:0] set_q, set_d;
  logic [WAY_BITS-1:0] victim_q, victim_d;

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [NUM_WAYS-2:0] tree_q  [NUM_SETS];
  logic [NUM_WAYS-2:0] tree_d  [NUM_SETS];

  logic [NUM_WAYS-2:0] hit_tree_in;
  logic [NUM_WAYS-2:0] fill_tree_in;
  logic [NUM_WAYS-1:0] fill_valid;
  logic [NUM_WAYS-2:0] hit_tree_out;
  logic [NUM_WAYS-2:0] ack_tree_out;
  logic [WAY_BITS-1:0] tree_victim;
  logic [WAY_BITS-1:0] inv_way;
  logic                inv_found;
  logic                ack_fire;

  // Victim outputs of the touch instances and the tree output of the walk
  // instance have no consumer.
  logic [WAY_BITS-1:0] hit_victim_unused;
  logic [WAY_BITS-1:0] ack_victim_unused;
  logic [NUM_WAYS-2:0] lookup_tree_unused;

  // fill_ack only counts while a victim is being presented
  assign ack_fire = (state_q == WAIT_ACK) && fill_ack;

  // Select the per-set state addressed by the hit and by the latched fill set
  always_comb begin
    hit_tree_in  = '0;
    fill_tree_in = '0;
    fill_valid   = '0;
    for (int s = 0; s < NUM_SETS; s++) begin
      if (hit_set == SET_BITS'(s)) begin
        hit_tree_in = tree_q[s];
      end
      if (set_q == SET_BITS'(s)) begin
        fill_tree_in = tree_q[s];
        fill_valid   = valid_q[s];
      end
    end
  end

  plru_tree #(.NUM_WAYS(NUM_WAYS), .WAY_BITS(WAY_BITS)) u_hit_tree (
    .tree_in    (hit_tree_in),
    .touch_way  (hit_way),
    .victim_way (hit_victim_unused),
    .tree_out   (hit_tree_out)
  );

  plru_tree #(.NUM_WAYS(NUM_WAYS), .WAY_BITS(WAY_BITS)) u_ack_tree (
    .tree_in    (fill_tree_in),
    .touch_way  (victim_q),
    .victim_way (ack_victim_unused),
    .tree_out   (ack_tree_out)
  );

  plru_tree #(.NUM_WAYS(NUM_WAYS), .WAY_BITS(WAY_BITS)) u_lookup_tree (
    .tree_in    (fill_tree_in),
    .touch_way  ('0),
    .victim_way (tree_victim),
    .tree_out   (lookup_tree_unused)
  );

  // Lowest-index invalid way of the fill set (scan downward so the lowest wins)
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!fill_valid[w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
    end
  end

  // FSM next state: IDLE -> LOOKUP -> WAIT_ACK -> IDLE; flush forces IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (fill_req) state_d = LOOKUP;
      LOOKUP:   state_d = WAIT_ACK;
      WAIT_ACK: if (fill_ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  // FSM outputs: busy for the whole fill, victim shown only while awaiting ack
  always_comb begin
    fill_busy    = (state_q != IDLE);
    victim_valid = (state_q == WAIT_ACK);
    victim_way   = victim_q;
  end

  // Latch the fill set on acceptance and the victim at the end of LOOKUP
  always_comb begin
    set_d    = set_q;
    victim_d = victim_q;
    if ((state_q == IDLE) && fill_req) begin
      set_d = fill_set;
    end
    if (state_q == LOOKUP) begin
      victim_d = inv_found ? inv_way : tree_victim;
    end
    if (flush) begin
      victim_d = '0;
    end
  end

  // Per-set valid/tree update: hit touch, fill_ack install+touch (wins on the
  // same set), flush clears everything
  always_comb begin
    for (int s = 0; s < NUM_SETS; s++) begin
      valid_d[s] = valid_q[s];
      tree_d[s]  = tree_q[s];
      if (hit_valid && (hit_set == SET_BITS'(s))) begin
        tree_d[s] = hit_tree_out;
      end
      if (ack_fire && (set_q == SET_BITS'(s))) begin
        tree_d[s]  = ack_tree_out;
        valid_d[s] = valid_q[s] | (NUM_WAYS'(1) << victim_q);
      end
      if (flush) begin
        valid_d[s] = '0;
        tree_d[s]  = '0;
      end
    end
  end

  // State registers; synchronous reset overrides everything including flush
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      set_q    <= '0;
      victim_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        tree_q[s]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      set_q    <= set_d;
      victim_q <= victim_d;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= valid_d[s];
        tree_q[s]  <= tree_d[s];
      end
    end
  end

endmodule

// File: tb/tb_plru_victim_sel.sv
// Directed bench for plru_victim_sel (4 ways, 4 sets).
// Latency: checks the 2-cycle fill_req -> victim_valid timing on every fill.
// Backpressure: checks that fill_req during WAIT_ACK is dropped.
module tb_plru_victim_sel;

  logic       clk = 1'b0;
  logic       reset, flush, hit_valid, fill_req, fill_ack;
  logic [1:0] hit_set, hit_way, fill_set;
  logic       fill_busy, victim_valid;
  logic [1:0] victim_way;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  plru_victim_sel #(.NUM_WAYS(4), .NUM_SETS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .hit_valid    (hit_valid),
    .hit_set      (hit_set),
    .hit_way      (hit_way),
    .fill_req     (fill_req),
    .fill_set     (fill_set),
    .fill_busy    (fill_busy),
    .victim_valid (victim_valid),
    .victim_way   (victim_way),
    .fill_ack     (fill_ack)
  );

  typedef struct {
    logic       hv;
    logic [1:0] hset;
    logic [1:0] hway;
    logic       fl;
    logic [1:0] fset;
    logic [1:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic hit(input logic [1:0] s, input logic [1:0] w);
    hit_valid = 1'b1;
    hit_set   = s;
    hit_way   = w;
    tick();
    hit_valid = 1'b0;
  endtask

  // Full fill handshake with timing checks and an ack
  task automatic do_fill(input logic [1:0] s, input logic [1:0] exp, input string tag);
    check($sformatf("%s.idle_busy", tag), 8'(fill_busy), 8'd0);
    fill_req = 1'b1;
    fill_set = s;
    tick();
    fill_req = 1'b0;
    check($sformatf("%s.busy_c1", tag), 8'(fill_busy), 8'd1);
    check($sformatf("%s.vvld_c1", tag), 8'(victim_valid), 8'd0);
    tick();
    check($sformatf("%s.vvld_c2", tag), 8'(victim_valid), 8'd1);
    check($sformatf("%s.way", tag), 8'(victim_way), 8'(exp));
    fill_ack = 1'b1;
    tick();
    fill_ack = 1'b0;
    check($sformatf("%s.vvld_ack", tag), 8'(victim_valid), 8'd0);
    check($sformatf("%s.busy_ack", tag), 8'(fill_busy), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; hit_valid = 1'b0; fill_req = 1'b0; fill_ack = 1'b0;
    hit_set = '0; hit_way = '0; fill_set = '0;

    tbl[0] = '{1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 2'd0};
    tbl[1] = '{1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 2'd1};
    tbl[2] = '{1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 2'd2};
    tbl[3] = '{1'b0, 2'd0, 2'd0, 1'b1, 2'd0, 2'd3};
    tbl[4] = '{1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0};
    tbl[5] = '{1'b1, 2'd0, 2'd1, 1'b0, 2'd0, 2'd0};
    tbl[6] = '{1'b1, 2'd0, 2'd2, 1'b0, 2'd0, 2'd0};
    tbl[7] = '{1'b1, 2'd0, 2'd3, 1'b1, 2'd0, 2'd0};
    tbl[8] = '{1'b1, 2'd0, 2'd0, 1'b1, 2'd0, 2'd2};
    tbl[9] = '{1'b0, 2'd0, 2'd0, 1'b1, 2'd3, 2'd0};

    tick();
    tick();
    check("rst.busy", 8'(fill_busy), 8'd0);
    check("rst.vvld", 8'(victim_valid), 8'd0);
    check("rst.way", 8'(victim_way), 8'd0);
    reset = 1'b0;
    tick();

    // Fills on an empty set, hit patterns, tree-driven victims, other set
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].hv) hit(tbl[i].hset, tbl[i].hway);
      if (tbl[i].fl) do_fill(tbl[i].fset, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Hit on the fill set and a second fill_req while in WAIT_ACK
    fill_req = 1'b1; fill_set = 2'd1;
    tick();
    fill_req = 1'b0;
    tick();
    check("wa.vvld", 8'(victim_valid), 8'd1);
    check("wa.way", 8'(victim_way), 8'd0);
    hit_valid = 1'b1; hit_set = 2'd1; hit_way = 2'd0;
    fill_req = 1'b1; fill_set = 2'd2;
    tick();
    hit_valid = 1'b0; fill_req = 1'b0;
    check("wa.way_after_hit", 8'(victim_way), 8'd0);
    tick();
    check("wa.way_held", 8'(victim_way), 8'd0);
    check("wa.vvld_held", 8'(victim_valid), 8'd1);
    fill_ack = 1'b1;
    tick();
    fill_ack = 1'b0;
    check("wa.busy_ack", 8'(fill_busy), 8'd0);
    tick();
    check("wa.no_queue_c1", 8'(fill_busy), 8'd0);
    tick();
    check("wa.no_queue_c2", 8'(victim_valid), 8'd0);
    do_fill(2'd1, 2'd1, "set1_second");

    // Flush during WAIT_ACK
    fill_req = 1'b1; fill_set = 2'd0;
    tick();
    fill_req = 1'b0;
    tick();
    check("fl.way_pre", 8'(victim_way), 8'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl.vvld", 8'(victim_valid), 8'd0);
    check("fl.busy", 8'(fill_busy), 8'd0);
    do_fill(2'd0, 2'd0, "post_flush");

    // Same-cycle hit (way 3) and fill_ack (way 1) on set 2
    do_fill(2'd2, 2'd0, "s2_first");
    fill_req = 1'b1; fill_set = 2'd2;
    tick();
    fill_req = 1'b0;
    tick();
    check("coll.way", 8'(victim_way), 8'd1);
    fill_ack = 1'b1;
    hit_valid = 1'b1; hit_set = 2'd2; hit_way = 2'd3;
    tick();
    fill_ack = 1'b0; hit_valid = 1'b0;
    check("coll.vvld", 8'(victim_valid), 8'd0);
    do_fill(2'd2, 2'd2, "s2_w2");
    do_fill(2'd2, 2'd3, "s2_w3");
    do_fill(2'd2, 2'd0, "s2_tree");
    do_fill(2'd2, 2'd2, "s2_tree2");

    // Reset while in LOOKUP
    fill_req = 1'b1; fill_set = 2'd1;
    tick();
    fill_req = 1'b0;
    check("rl.busy_pre", 8'(fill_busy), 8'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rl.busy", 8'(fill_busy), 8'd0);
    check("rl.vvld", 8'(victim_valid), 8'd0);
    check("rl.way", 8'(victim_way), 8'd0);
    tick();
    check("rl.vvld_after", 8'(victim_valid), 8'd0);
    do_fill(2'd0, 2'd0, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
